sc_dbg_rptr_arb: RTL and testbench
==================================

// Module: sc_dbg_rptr_arb
// PURPOSE
//  Parametrised L2 debug-bus repeater and arbiter. Takes NCH debug-bus channels,
//  each carrying DW data bits plus one valid bit at the MSB. Each cycle it picks
//  one valid channel, either by fixed priority or by round-robin. The chosen
//  channel is registered through a STAGES-deep pipeline that can be frozen.
//  Sits between the L2 bank debug muxes and the chip-level debug port. Counts
//  cycles in which more than one source is valid (collisions).
// PARAMETERS
//  NCH     4   number of input channels, 2..8
//  DW      40  data bits per channel, excluding the valid bit
//  STAGES  1   register stages from input to output, 1..4
//  RR      0   0 = fixed priority (lowest index wins); 1 = round-robin
//  SW      2   width of the source-index field, must equal clog2(NCH)
// PORTS
//  rclk        in   1            clock
//  arst_l      in   1            asynchronous reset, active low
//  dbgbus_in   in   NCH*(DW+1)   channel i occupies bits [i*(DW+1) +: DW+1];
//                                its MSB is valid_i, the rest is data_i
//  freeze      in   1            1 = hold pipeline, RR pointer and counter
//  clr_cnt     in   1            synchronous clear of collide_cnt
//  dbgbus_out  out  DW           selected data, registered
//  dbgbus_vld  out  1            selected data is valid, registered
//  dbgbus_src  out  SW           index of the winning channel, registered
//  collide_cnt out  8            saturating count of collision cycles
// BEHAVIOUR
//  Reset:
//   - arst_l low asynchronously clears all pipeline stages and the RR pointer
//     (ptr) to 0, and clears collide_cnt.
//   - While in reset: dbgbus_out=0, dbgbus_vld=0, dbgbus_src=0, collide_cnt=0.
//   - Deassertion is synchronised outside this block. The first capture
//     happens on the first rclk edge with arst_l high.
//  Select stage (combinational, feeds stage 1):
//   - RR=0: the winner is the lowest index i with valid_i=1.
//   - RR=1: the winner is the first valid index found searching
//     ptr, ptr+1, ..., wrapping modulo NCH.
//   - No valid channel: stage-1 inputs are data=0, vld=0, src=0.
//  Pipeline:
//   - STAGES registers in series; each holds {vld, src, data}.
//   - Latency: inputs sampled at edge N appear on the outputs after edge
//     N+STAGES-1. With STAGES=1 the outputs change on the edge that samples.
//   - freeze=1: every stage holds its value, and inputs in that cycle are
//     dropped, not queued.
//   - freeze=0: all stages shift by one.
//   - Freeze is glitch-free: the outputs do not change while freeze=1.
//  RR pointer (RR=1 only):
//   - When freeze=0 and some channel is valid, ptr <= (winner+1) mod NCH.
//   - Otherwise ptr holds.
//   - With RR=0, ptr is unused and stays 0.
//  Collision counter:
//   - A collision is a cycle with two or more valid_i=1 and freeze=0.
//   - clr_cnt=1 sets the counter to 0 on the next edge. Clear beats
//     increment and ignores freeze.
//   - Otherwise the counter increments by 1 on a collision and saturates
//     at 8'hFF; it never wraps.
//   - The count reflects input-side events; it is not delayed by STAGES.
//  Simultaneous events:
//   - freeze and clr_cnt together: the counter clears and the pipeline holds.
//   - Reset mid-freeze: reset wins, and all state is cleared.
//  Illegal settings:
//   - NCH outside 2..8 or STAGES outside 1..4 is a build-time error, flagged
//     by a generate-time check.
// TESTING
//  1 Reset: hold arst_l=0 with all channels valid -> every output is 0.
//    Release -> the first captured value appears STAGES-1 edges after
//    the first sampling edge.
//  2 Priority: RR=0, NCH=4, ch1 and ch3 valid (data 'h11, 'h33)
//    -> dbgbus_out='h11, src=1, vld=1; collide_cnt goes 0->1 per cycle held.
//  3 Round-robin: RR=1, all 4 valid for 6 cycles -> src sequence
//    0,1,2,3,0,1. Only ch2 valid next -> src=2, and then ptr=3.
//  4 Freeze: STAGES=3, stream distinct values, raise freeze for 4 cycles
//    -> outputs constant; on release the next output is the pre-freeze
//    stage-2 value, and ptr and counter are unchanged across the freeze.
//  5 Saturation and clear: force 300 collision cycles -> collide_cnt=8'hFF.
//    clr_cnt together with a collision -> 0 next edge, then increments to 1.
//  6 Idle and async reset: no channel valid -> vld=0, data=0, src=0.
//    Assert arst_l mid-stream, away from the clock edge -> outputs go to 0
//    immediately.

Source files
------------

// File: rtl/sc_dbg_rptr_arb.sv
// L2 debug-bus repeater/arbiter: picks one valid channel per cycle (fixed priority or
// round-robin), carries it through a freezable STAGES-deep pipeline, and counts collisions.
module sc_dbg_rptr_arb #(
  parameter int NCH    = 4,
  parameter int DW     = 40,
  parameter int STAGES = 1,
  parameter int RR     = 0,
  parameter int SW     = 2
) (
  input  logic                  rclk,
  input  logic                  arst_l,
  input  logic [NCH*(DW+1)-1:0] dbgbus_in,
  input  logic                  freeze,
  input  logic                  clr_cnt,
  output logic [DW-1:0]         dbgbus_out,
  output logic                  dbgbus_vld,
  output logic [SW-1:0]         dbgbus_src,
  output logic [7:0]            collide_cnt
);

  localparam int EW = DW + SW + 1;

  if (NCH < 2 || NCH > 8) begin : g_bad_nch
    $error("sc_dbg_rptr_arb: NCH must be in 2..8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sc_dbg_rptr_arb: STAGES must be in 1..4");
  end
  if (SW != $clog2(NCH)) begin : g_bad_sw
    $error("sc_dbg_rptr_arb: SW must equal clog2(NCH)");
  end

  logic [NCH-1:0] ch_vld;
  logic [DW-1:0]  ch_data [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch_vld[g]  = dbgbus_in[g*(DW+1) + DW];
    assign ch_data[g] = dbgbus_in[g*(DW+1) +: DW];
  end

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] base_c, idx_c;
  logic          win_vld;
  logic [SW-1:0] win_src;
  logic [DW-1:0] win_data;

  // Fixed priority is the same circular search anchored at channel 0.
  assign base_c = (RR != 0) ? ptr_q : '0;

  always_comb begin
    win_vld  = 1'b0;
    win_src  = '0;
    win_data = '0;
    idx_c    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_c = SW'((int'(base_c) + k) % NCH);
      if (!win_vld && ch_vld[idx_c]) begin
        win_vld  = 1'b1;
        win_src  = idx_c;
        win_data = ch_data[idx_c];
      end
    end
  end

  logic [3:0] nvld_c;
  logic       collide_c;

  always_comb begin
    nvld_c = '0;
    for (int i = 0; i < NCH; i++) begin
      nvld_c = nvld_c + {3'b000, ch_vld[i]};
    end
  end

  assign collide_c = (nvld_c > 4'd1);

  always_comb begin
    ptr_d = ptr_q;
    if (RR != 0 && !freeze && win_vld) begin
      ptr_d = (win_src == SW'(NCH - 1)) ? '0 : win_src + SW'(1);
    end
  end

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (collide_c && !freeze && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  logic [EW-1:0] sel_d;
  logic [EW-1:0] pipe_q [STAGES];

  assign sel_d = {win_vld, win_src, win_data};

  // Stage boundary: select -> pipe_q[0] -> ... -> pipe_q[STAGES-1] (outputs).
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_q[s] <= '0;
      end
    end else if (!freeze) begin
      pipe_q[0] <= sel_d;
      for (int s = 1; s < STAGES; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign {dbgbus_vld, dbgbus_src, dbgbus_out} = pipe_q[STAGES-1];
  assign collide_cnt = cnt_q;

endmodule

// File: tb/tb_sc_dbg_rptr_arb.sv
// Bench for sc_dbg_rptr_arb: a fixed-priority STAGES=1 instance and a round-robin STAGES=3
// instance share one stimulus and are checked against a queue-based reference model.
module tb_sc_dbg_rptr_arb;
  localparam int NCH = 4;
  localparam int DW  = 40;
  localparam int SW  = 2;
  localparam int S0  = 1;
  localparam int S1  = 3;
  localparam int EW  = DW + SW + 1;

  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  logic freeze = 1'b0;
  logic clr_cnt = 1'b0;
  logic [NCH-1:0] vld_t = '0;
  logic [DW-1:0] data_t [NCH];
  logic [NCH*(DW+1)-1:0] din;

  logic [DW-1:0] out0, out1;
  logic vld0, vld1;
  logic [SW-1:0] src0, src1;
  logic [7:0] cnt0, cnt1;

  int nc = 0;
  int nf = 0;

  logic [EW-1:0] mp0 [S0];
  logic [EW-1:0] mp1 [S1];
  logic [SW-1:0] m_ptr1;
  logic [7:0] m_cnt;

  wire [EW-1:0] o0 = {vld0, src0, out0};
  wire [EW-1:0] o1 = {vld1, src1, out1};

  always #5 rclk = ~rclk;

  always_comb begin
    din = '0;
    for (int i = 0; i < NCH; i++) din[i*(DW+1) +: DW+1] = {vld_t[i], data_t[i]};
  end

  sc_dbg_rptr_arb #(.NCH(NCH), .DW(DW), .STAGES(S0), .RR(0), .SW(SW)) u_pri (
    .rclk(rclk), .arst_l(arst_l), .dbgbus_in(din), .freeze(freeze), .clr_cnt(clr_cnt),
    .dbgbus_out(out0), .dbgbus_vld(vld0), .dbgbus_src(src0), .collide_cnt(cnt0));

  sc_dbg_rptr_arb #(.NCH(NCH), .DW(DW), .STAGES(S1), .RR(1), .SW(SW)) u_rr (
    .rclk(rclk), .arst_l(arst_l), .dbgbus_in(din), .freeze(freeze), .clr_cnt(clr_cnt),
    .dbgbus_out(out1), .dbgbus_vld(vld1), .dbgbus_src(src1), .collide_cnt(cnt1));

  // Circular search from ptr; fixed priority is ptr=0.
  function automatic logic [EW-1:0] pick(int ptr);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (ptr + k) % NCH;
      if (vld_t[idx]) return {1'b1, idx[SW-1:0], data_t[idx]};
    end
    return '0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S0; s++) mp0[s] = '0;
    for (int s = 0; s < S1; s++) mp1[s] = '0;
    m_ptr1 = '0;
    m_cnt = '0;
  endtask

  task automatic model_edge();
    logic [EW-1:0] n0, n1;
    int nv;
    n0 = pick(0);
    n1 = pick(int'(m_ptr1));
    nv = $countones(vld_t);
    if (!freeze) begin
      for (int s = S0 - 1; s > 0; s--) mp0[s] = mp0[s-1];
      mp0[0] = n0;
      for (int s = S1 - 1; s > 0; s--) mp1[s] = mp1[s-1];
      mp1[0] = n1;
      if (n1[EW-1]) m_ptr1 = SW'((int'(n1[EW-2 -: SW]) + 1) % NCH);
    end
    if (clr_cnt) m_cnt = '0;
    else if (!freeze && nv >= 2 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic step();
    model_edge();
    @(posedge rclk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      data_t[i] = r[DW-1:0];
    end
  endtask

  task automatic pulse_reset();
    arst_l = 1'b0;
    #2;
    arst_l = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    vld_t = '1;
    rand_data();
    #12;
    nc++;
    if ({o0, o1, cnt0, cnt1} !== '0) begin
      nf++;
      $display("FAIL reset_hold: got %h %h %h %h want all 0", o0, o1, cnt0, cnt1);
    end
    arst_l = 1'b1;
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      step();
      nc++;
      if ({o0, o1, cnt0, cnt1} !== {mp0[S0-1], mp1[S1-1], m_cnt, m_cnt}) begin
        nf++;
        $display("FAIL reset_release k=%0d: got %h %h %h %h want %h %h %h", k, o0, o1, cnt0, cnt1,
                 mp0[S0-1], mp1[S1-1], m_cnt);
      end
    end
    nc++;
    if ({vld1, src1, out1} !== {1'b1, 2'd0, data_t[0]}) begin
      nf++;
      $display("FAIL reset_latency: got %h want %h", o1, {1'b1, 2'd0, data_t[0]});
    end
  endtask

  task automatic test_priority();
    clr_cnt = 1'b1;
    vld_t = '0;
    step();
    clr_cnt = 1'b0;
    rand_data();
    data_t[1] = 40'h11;
    data_t[3] = 40'h33;
    vld_t = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      step();
      nc++;
      if ({vld0, src0, out0, cnt0} !== {1'b1, 2'd1, 40'h11, 8'(k)}) begin
        nf++;
        $display("FAIL priority k=%0d: got vld=%b src=%0d data=%h cnt=%0d want 1 1 11 %0d",
                 k, vld0, src0, out0, cnt0, k);
      end
      nc++;
      if ({o1, cnt1} !== {mp1[S1-1], m_cnt}) begin
        nf++;
        $display("FAIL priority_rr k=%0d: got %h %h want %h %h", k, o1, cnt1, mp1[S1-1], m_cnt);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] exp_src [8];
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    pulse_reset();
    rand_data();
    for (int k = 1; k <= 10; k++) begin
      if (k <= 6) vld_t = 4'b1111;
      else if (k == 7) vld_t = 4'b0100;
      else if (k == 8) vld_t = 4'b1101;
      else vld_t = 4'b0000;
      step();
      if (k >= 3) begin
        nc++;
        if ({vld1, src1} !== {1'b1, exp_src[k-3]}) begin
          nf++;
          $display("FAIL rr_seq k=%0d: got vld=%b src=%0d want 1 %0d", k, vld1, src1, exp_src[k-3]);
        end
      end
      nc++;
      if ({o0, o1, cnt0, cnt1} !== {mp0[S0-1], mp1[S1-1], m_cnt, m_cnt}) begin
        nf++;
        $display("FAIL rr_model k=%0d: got %h %h %h %h want %h %h %h", k, o0, o1, cnt0, cnt1,
                 mp0[S0-1], mp1[S1-1], m_cnt);
      end
    end
  endtask

  task automatic test_freeze();
    logic [EW-1:0] hold1, hold0, next1;
    logic [7:0] hold_cnt;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      vld_t = 4'($urandom_range(1, 15));
      step();
    end
    hold0 = mp0[S0-1];
    hold1 = mp1[S1-1];
    next1 = mp1[S1-2];
    hold_cnt = m_cnt;
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      vld_t = 4'b1111;
      step();
      nc++;
      if ({o0, o1, cnt0, cnt1} !== {hold0, hold1, hold_cnt, hold_cnt}) begin
        nf++;
        $display("FAIL freeze_hold k=%0d: got %h %h %h %h want %h %h %h", k, o0, o1, cnt0, cnt1,
                 hold0, hold1, hold_cnt);
      end
    end
    freeze = 1'b0;
    vld_t = '0;
    step();
    nc++;
    if (o1 !== next1) begin
      nf++;
      $display("FAIL freeze_release: got %h want %h", o1, next1);
    end
    freeze = 1'b1;
    clr_cnt = 1'b1;
    vld_t = 4'b0111;
    hold1 = mp1[S1-1];
    step();
    freeze = 1'b0;
    clr_cnt = 1'b0;
    nc++;
    if ({o1, cnt0, cnt1} !== {hold1, 8'h00, 8'h00}) begin
      nf++;
      $display("FAIL freeze_clr: got %h %h %h want %h 00 00", o1, cnt0, cnt1, hold1);
    end
  endtask

  task automatic test_saturation();
    vld_t = 4'b1111;
    rand_data();
    for (int k = 0; k < 300; k++) step();
    nc++;
    if ({cnt0, cnt1} !== {8'hFF, 8'hFF}) begin
      nf++;
      $display("FAIL saturate: got %h %h want ff ff", cnt0, cnt1);
    end
    clr_cnt = 1'b1;
    step();
    nc++;
    if ({cnt0, cnt1} !== 16'h0000) begin
      nf++;
      $display("FAIL clear_beats_inc: got %h %h want 00 00", cnt0, cnt1);
    end
    clr_cnt = 1'b0;
    step();
    nc++;
    if ({cnt0, cnt1} !== 16'h0101) begin
      nf++;
      $display("FAIL inc_after_clear: got %h %h want 01 01", cnt0, cnt1);
    end
  endtask

  task automatic test_idle_async();
    vld_t = '0;
    rand_data();
    for (int k = 0; k < 3; k++) step();
    nc++;
    if ({o0, o1} !== '0) begin
      nf++;
      $display("FAIL idle: got %h %h want 0 0", o0, o1);
    end
    for (int k = 0; k < 4; k++) begin
      rand_data();
      vld_t = 4'($urandom_range(3, 15));
      step();
    end
    #3;
    arst_l = 1'b0;
    #1;
    nc++;
    if ({o0, o1, cnt0, cnt1} !== '0) begin
      nf++;
      $display("FAIL async_reset: got %h %h %h %h want all 0", o0, o1, cnt0, cnt1);
    end
    #1;
    arst_l = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int k = 0; k < 250; k++) begin
      rand_data();
      vld_t = 4'($urandom());
      freeze = ($urandom_range(0, 7) == 0);
      clr_cnt = ($urandom_range(0, 31) == 0);
      step();
      nc++;
      if ({o0, o1, cnt0, cnt1} !== {mp0[S0-1], mp1[S1-1], m_cnt, m_cnt}) begin
        nf++;
        $display("FAIL random k=%0d: got %h %h %h %h want %h %h %h", k, o0, o1, cnt0, cnt1,
                 mp0[S0-1], mp1[S1-1], m_cnt);
      end
    end
    freeze = 1'b0;
    clr_cnt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) data_t[i] = '0;
    model_reset();
    test_reset();
    test_priority();
    test_round_robin();
    test_freeze();
    test_saturation();
    test_idle_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
